// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO drain block: state encoding and default word width.
package fifo_pkg;
    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } drain_state_t;
endpackage

// File: rtl/fifo_drain_if.sv
// FIFO-side and downstream-side handshake bundle of fifo_drain; master is the drain engine.
interface fifo_drain_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();
    logic             empty;
    logic [WIDTH-1:0] rd_data;
    logic             read;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        input  empty,
        input  rd_data,
        input  out_ready,
        output read,
        output out_data,
        output out_valid
    );

    modport slave (
        output empty,
        output rd_data,
        output out_ready,
        input  read,
        input  out_data,
        input  out_valid
    );
endinterface

// File: rtl/fifo_drain_counter.sv
// drain_counter: counts accepted words, wrapping modulo 2^CNT_W.
// Latency: count updates on the edge where inc is sampled high.
// Backpressure: none; inc is a single-cycle strobe per handshake.
module drain_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/fifo_drain.sv
// fifo_drain: pops words from a FIFO control unit and presents them downstream (FIFO_DRAIN_COUNT_EN adds drained_count).
// Latency: empty=0 seen in IDLE -> read next cycle -> out_valid two edges later; one word per 3 cycles.
// Backpressure: word held in HOLD with out_data stable until out_ready; no further pops meanwhile.
module fifo_drain
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    fifo_drain_if.master     bus,
`ifdef FIFO_DRAIN_COUNT_EN
    output logic [CNT_W-1:0] drained_count,
`endif
    output logic             busy
);
    drain_state_t     state;
    logic             read_q;
    logic             valid_q;
    logic             busy_q;
    logic [WIDTH-1:0] data_q;

    // All outputs are registered alongside the state so they never glitch on inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            read_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!bus.empty) begin
                        state  <= FETCH;
                        read_q <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                FETCH: begin
                    state  <= WAIT;
                    read_q <= 1'b0;
                end
                WAIT: begin
                    // rd_data is valid in the cycle after the pop edge
                    state   <= HOLD;
                    data_q  <= bus.rd_data;
                    valid_q <= 1'b1;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        if (!bus.empty) begin
                            state  <= FETCH;
                            read_q <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    read_q  <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.read      = read_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign busy          = busy_q;

`ifdef FIFO_DRAIN_COUNT_EN
    logic handshake;

    assign handshake = (state == HOLD) && bus.out_ready;

    drain_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (handshake),
        .count (drained_count)
    );
`endif
endmodule

// File: tb/tb_fifo_drain.sv
// Directed vector bench for fifo_drain; count checks are active when FIFO_DRAIN_COUNT_EN is defined.
module tb_fifo_drain;
    logic       clk = 1'b0;
    logic       reset;
    logic       busy;
`ifdef FIFO_DRAIN_COUNT_EN
    logic [1:0] drained_count;
`endif

    fifo_drain_if #(.WIDTH(4)) bus ();

    fifo_drain #(
        .WIDTH (4),
        .CNT_W (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
`ifdef FIFO_DRAIN_COUNT_EN
        .drained_count (drained_count),
`endif
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       emp;
        logic [3:0] rd;
        logic       rdy;
        logic       e_read;
        logic       e_valid;
        logic [3:0] e_data;
        logic       e_busy;
        logic [1:0] e_cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, let one rising edge pass, sample 1ns later.
    task automatic step(input logic r, input logic e, input logic [3:0] d, input logic rdy);
        @(negedge clk);
        reset         = r;
        bus.empty     = e;
        bus.rd_data   = d;
        bus.out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic er, input logic ev, input logic [3:0] ed,
                           input logic eb, input logic [1:0] ec);
        chk({tag, ".read"},      32'(bus.read),      32'(er));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ev));
        chk({tag, ".out_data"},  32'(bus.out_data),  32'(ed));
        chk({tag, ".busy"},      32'(busy),          32'(eb));
`ifdef FIFO_DRAIN_COUNT_EN
        chk({tag, ".count"},     32'(drained_count), 32'(ec));
`else
        if (ec === 2'bxx) $display("count expectation undefined in %s", tag);
`endif
    endtask

    initial begin
        reset         = 1'b1;
        bus.empty     = 1'b0;
        bus.rd_data   = 4'h0;
        bus.out_ready = 1'b0;

        //             rst  emp  rd     rdy   read valid data   busy cnt
        // reset held with empty=0, then release with nothing to pop
        tbl.push_back('{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0});
        tbl.push_back('{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0});
        tbl.push_back('{1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0});
        // single word 0xA, accepted immediately, FIFO then empty
        tbl.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 2'd0});
        tbl.push_back('{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 2'd0});
        tbl.push_back('{1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 1'b1, 4'hA, 1'b1, 2'd0});
        tbl.push_back('{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 4'hA, 1'b0, 2'd1});
        tbl.push_back('{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 4'hA, 1'b0, 2'd1});
        // word 0x3 stalled 5 cycles by out_ready=0 while empty=0
        tbl.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'hA, 1'b1, 2'd1});
        tbl.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'hA, 1'b1, 2'd1});
        tbl.push_back('{1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 1'b1, 4'h3, 1'b1, 2'd1});
        for (int k = 0; k < 5; k++)
            tbl.push_back('{1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 4'h3, 1'b1, 2'd1});
        tbl.push_back('{1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 4'h3, 1'b0, 2'd2});
        // back-to-back A, B, C at one word per 3 cycles
        tbl.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h3, 1'b1, 2'd2});
        tbl.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h3, 1'b1, 2'd2});
        tbl.push_back('{1'b0, 1'b0, 4'hA, 1'b1, 1'b0, 1'b1, 4'hA, 1'b1, 2'd2});
        tbl.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'hA, 1'b1, 2'd3});
        tbl.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'hA, 1'b1, 2'd3});
        tbl.push_back('{1'b0, 1'b0, 4'hB, 1'b1, 1'b0, 1'b1, 4'hB, 1'b1, 2'd3});
        tbl.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'hB, 1'b1, 2'd0});
        tbl.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'hB, 1'b1, 2'd0});
        tbl.push_back('{1'b0, 1'b0, 4'hC, 1'b1, 1'b0, 1'b1, 4'hC, 1'b1, 2'd0});
        tbl.push_back('{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 4'hC, 1'b0, 2'd1});

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].emp, tbl[i].rd, tbl[i].rdy);
            chk_all($sformatf("v%0d", i), tbl[i].e_read, tbl[i].e_valid, tbl[i].e_data,
                    tbl[i].e_busy, tbl[i].e_cnt);
        end

        // idle with empty=1 must never pop, even with out_ready high
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 4'h9, 1'b1);
            chk($sformatf("idle%0d.read", i), 32'(bus.read), 32'd0);
            chk($sformatf("idle%0d.busy", i), 32'(busy), 32'd0);
        end

        // reset while in WAIT drops the word and does not re-pop
        step(1'b0, 1'b0, 4'h0, 1'b0);
        chk_all("rw_fetch", 1'b1, 1'b0, 4'hC, 1'b1, 2'd1);
        step(1'b0, 1'b1, 4'h0, 1'b0);
        chk_all("rw_wait", 1'b0, 1'b0, 4'hC, 1'b1, 2'd1);
        step(1'b1, 1'b0, 4'h5, 1'b1);
        chk_all("rw_reset", 1'b0, 1'b0, 4'h0, 1'b0, 2'd0);
        step(1'b0, 1'b1, 4'h5, 1'b1);
        chk_all("rw_after", 1'b0, 1'b0, 4'h0, 1'b0, 2'd0);

        // reset while stalled in HOLD clears the presented word
        step(1'b0, 1'b0, 4'h0, 1'b0);
        step(1'b0, 1'b1, 4'h0, 1'b0);
        step(1'b0, 1'b1, 4'h7, 1'b0);
        chk_all("rh_hold", 1'b0, 1'b1, 4'h7, 1'b1, 2'd0);
        step(1'b1, 1'b0, 4'h7, 1'b0);
        chk_all("rh_reset", 1'b0, 1'b0, 4'h0, 1'b0, 2'd0);
        step(1'b0, 1'b1, 4'h7, 1'b1);
        chk_all("rh_after", 1'b0, 1'b0, 4'h0, 1'b0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
